// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: owns the PC, issues req/ack fetches and holds one
// fetched {PC, inst} entry for decode, with stall hold and branch redirect.
module if_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        start_i,
  input  logic        stall_i,
  input  logic        branch_taken_i,
  input  logic [31:0] branch_target_i,
  output logic        mem_req_o,
  output logic [31:0] mem_addr_o,
  input  logic        mem_ack_i,
  input  logic [31:0] mem_data_i,
  output logic [31:0] pc_o,
  output logic [31:0] inst_o,
  output logic        inst_valid_o,
  output logic        fetch_busy_o
);

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_KILL} state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] redir_q, redir_d;
  logic        pend_q, pend_d;
  logic [31:0] out_pc_q, out_pc_d;
  logic [31:0] out_inst_q, out_inst_d;
  logic        out_valid_q, out_valid_d;

  logic        req;
  logic        consumed;
  logic [31:0] target;

  assign target   = branch_target_i & 32'hFFFF_FFFC;
  assign consumed = out_valid_q & ~stall_i;
  assign req      = ((state_q == S_FETCH) & (pend_q | ~out_valid_q | ~stall_i))
                  | (state_q == S_KILL);

  // pc_q is left untouched while a killed miss drains, so the address of the
  // abandoned request stays stable until its ack; the redirect lives in redir_q.
  assign mem_req_o    = req;
  assign mem_addr_o   = pc_q;
  assign fetch_busy_o = req & ~mem_ack_i;
  assign pc_o         = out_pc_q;
  assign inst_o       = out_inst_q;
  assign inst_valid_o = out_valid_q;

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    redir_d     = redir_q;
    pend_d      = pend_q;
    out_pc_d    = out_pc_q;
    out_inst_d  = out_inst_q;
    out_valid_d = out_valid_q;

    if (req) begin
      pend_d = ~mem_ack_i;
    end

    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          state_d = S_FETCH;
        end
      end
      S_FETCH: begin
        if (branch_taken_i) begin
          out_valid_d = 1'b0;
          if (req & ~mem_ack_i) begin
            redir_d = target;
            state_d = S_KILL;
          end else begin
            pc_d = target;
          end
        end else if (req & mem_ack_i) begin
          out_inst_d  = mem_data_i;
          out_pc_d    = pc_q;
          out_valid_d = 1'b1;
          pc_d        = pc_q + 32'd4;
        end else if (consumed) begin
          out_valid_d = 1'b0;
        end
      end
      S_KILL: begin
        out_valid_d = 1'b0;
        if (branch_taken_i) begin
          redir_d = target;
        end
        if (mem_ack_i) begin
          pc_d    = branch_taken_i ? target : redir_q;
          state_d = S_FETCH;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q     <= S_IDLE;
      pc_q        <= RESET_PC;
      redir_q     <= 32'h0;
      pend_q      <= 1'b0;
      out_pc_q    <= RESET_PC;
      out_inst_q  <= 32'h0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      redir_q     <= redir_d;
      pend_q      <= pend_d;
      out_pc_q    <= out_pc_d;
      out_inst_q  <= out_inst_d;
      out_valid_q <= out_valid_d;
    end
  end

endmodule

// File: tb/tb_if_fetch_unit.sv
// Directed bench for if_fetch_unit with a latency-programmable memory model
// and a queue of expected {pc, inst} entries.
module tb_if_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_i;
  logic        start_i, stall_i, branch_taken_i, mem_ack_i;
  logic [31:0] branch_target_i, mem_data_i;
  logic        mem_req_o, inst_valid_o, fetch_busy_o;
  logic [31:0] mem_addr_o, pc_o, inst_o;

  logic        start1_i, ack1_i;
  logic        stall1_i, br1_i;
  logic [31:0] tgt1_i, data1_i;
  logic        req1_o, valid1_o, busy1_o;
  logic [31:0] addr1_o, pc1_o, inst1_o;

  always #5 clk = ~clk;

  if_fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
    .clk_i(clk), .rst_i(rst_i), .start_i(start_i), .stall_i(stall_i),
    .branch_taken_i(branch_taken_i), .branch_target_i(branch_target_i),
    .mem_req_o(mem_req_o), .mem_addr_o(mem_addr_o), .mem_ack_i(mem_ack_i),
    .mem_data_i(mem_data_i), .pc_o(pc_o), .inst_o(inst_o),
    .inst_valid_o(inst_valid_o), .fetch_busy_o(fetch_busy_o)
  );

  if_fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) dut_wrap (
    .clk_i(clk), .rst_i(rst_i), .start_i(start1_i), .stall_i(stall1_i),
    .branch_taken_i(br1_i), .branch_target_i(tgt1_i),
    .mem_req_o(req1_o), .mem_addr_o(addr1_o), .mem_ack_i(ack1_i),
    .mem_data_i(data1_i), .pc_o(pc1_o), .inst_o(inst1_o),
    .inst_valid_o(valid1_o), .fetch_busy_o(busy1_o)
  );

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } ent_t;

  ent_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;
  int   lat      = 0;
  int   wait_cnt = 0;
  bit   killing  = 1'b0;
  logic acked;

  function automatic logic [31:0] memf(input logic [31:0] a);
    return (a == 32'h8) ? 32'h0050_0093 : (a ^ 32'hDEAD_0000);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive inputs at the falling edge, answer the request,
  // predict the entry and compare it one edge later.
  task automatic cyc(input logic st, input logic br, input logic [31:0] tgt,
                     input logic sta, output logic ack_out);
    ent_t e;
    logic push;
    start_i = sta; stall_i = st; branch_taken_i = br; branch_target_i = tgt;
    #1;
    ack_out    = mem_req_o && (wait_cnt >= lat);
    mem_ack_i  = ack_out;
    mem_data_i = ack_out ? memf(mem_addr_o) : 32'h0;
    push       = ack_out && !br && !killing;
    if (push) exp_q.push_back({mem_addr_o, memf(mem_addr_o)});
    if (ack_out) begin
      wait_cnt = 0;
      killing  = 1'b0;
    end else if (mem_req_o) begin
      wait_cnt++;
      if (br) killing = 1'b1;
    end
    @(posedge clk);
    #1;
    start_i = 1'b0; mem_ack_i = 1'b0; branch_taken_i = 1'b0;
    if (push) begin
      e = exp_q.pop_front();
      chk("sb_valid", {31'b0, inst_valid_o}, 32'd1);
      chk("sb_pc", pc_o, e.pc);
      chk("sb_inst", inst_o, e.inst);
      $display("fetch pc=%h inst=%h", pc_o, inst_o);
    end
    @(negedge clk);
  endtask

  initial begin
    rst_i = 1'b0; start_i = 1'b0; stall_i = 1'b0; branch_taken_i = 1'b0;
    branch_target_i = 32'h0; mem_ack_i = 1'b0; mem_data_i = 32'h0;
    start1_i = 1'b0; ack1_i = 1'b0; stall1_i = 1'b0; br1_i = 1'b0;
    tgt1_i = 32'h0; data1_i = 32'h0;

    repeat (2) @(negedge clk);
    chk("rst_req", {31'b0, mem_req_o}, 32'd0);
    chk("rst_valid", {31'b0, inst_valid_o}, 32'd0);
    chk("rst_pc", pc_o, 32'h0);
    chk("rst_inst", inst_o, 32'h0);
    chk("rst_busy", {31'b0, fetch_busy_o}, 32'd0);
    chk("rst_wrap_pc", pc1_o, 32'hFFFF_FFFC);
    rst_i = 1'b1;

    // T1: start and back-to-back hits
    cyc(1'b0, 1'b0, 32'h0, 1'b1, acked);
    for (int i = 0; i < 3; i++) begin
      chk("t1_req", {31'b0, mem_req_o}, 32'd1);
      chk("t1_addr", mem_addr_o, 32'(4 * i));
      cyc(1'b0, 1'b0, 32'h0, 1'b0, acked);
    end

    // T2: stall holds the entry and suppresses issue
    for (int i = 0; i < 3; i++) begin
      cyc(1'b1, 1'b0, 32'h0, 1'b0, acked);
      chk("t2_req", {31'b0, mem_req_o}, 32'd0);
      chk("t2_pc", pc_o, 32'h8);
      chk("t2_inst", inst_o, 32'h0050_0093);
      chk("t2_valid", {31'b0, inst_valid_o}, 32'd1);
    end
    stall_i = 1'b0;
    #1;
    chk("t2_addr", mem_addr_o, 32'hC);
    cyc(1'b0, 1'b0, 32'h0, 1'b0, acked);

    // T3: redirect with a hit in the same cycle
    cyc(1'b0, 1'b1, 32'h0000_0043, 1'b0, acked);
    chk("t3_valid", {31'b0, inst_valid_o}, 32'd0);
    chk("t3_addr", mem_addr_o, 32'h40);
    cyc(1'b0, 1'b0, 32'h0, 1'b0, acked);
    cyc(1'b0, 1'b1, 32'h10, 1'b0, acked);
    chk("t4_start_addr", mem_addr_o, 32'h10);

    // T4: redirect during a 5-cycle miss
    lat = 5;
    cyc(1'b0, 1'b0, 32'h0, 1'b0, acked);
    chk("t4_busy", {31'b0, fetch_busy_o}, 32'd1);
    cyc(1'b0, 1'b1, 32'h80, 1'b0, acked);
    chk("t4_kill_valid", {31'b0, inst_valid_o}, 32'd0);
    chk("t4_hold", mem_addr_o, 32'h10);
    for (int k = 0; k < 8; k++) begin
      cyc(1'b0, 1'b0, 32'h0, 1'b0, acked);
      if (acked) break;
      chk("t4_hold_addr", mem_addr_o, 32'h10);
      chk("t4_hold_req", {31'b0, mem_req_o}, 32'd1);
    end
    chk("t4_acked", {31'b0, acked}, 32'd1);
    chk("t4_drop", {31'b0, inst_valid_o}, 32'd0);
    chk("t4_addr", mem_addr_o, 32'h80);
    lat = 0;
    cyc(1'b0, 1'b0, 32'h0, 1'b0, acked);

    // T5: second branch in KILL lands with the ack
    lat = 3;
    cyc(1'b0, 1'b0, 32'h0, 1'b0, acked);
    cyc(1'b0, 1'b1, 32'h80, 1'b0, acked);
    chk("t5_kill_valid", {31'b0, inst_valid_o}, 32'd0);
    cyc(1'b0, 1'b0, 32'h0, 1'b0, acked);
    cyc(1'b0, 1'b1, 32'hC0, 1'b0, acked);
    chk("t5_ack", {31'b0, acked}, 32'd1);
    chk("t5_drop", {31'b0, inst_valid_o}, 32'd0);
    chk("t5_addr", mem_addr_o, 32'hC0);
    chk("t5_req", {31'b0, mem_req_o}, 32'd1);

    // T6: asynchronous reset in the middle of a miss
    lat = 4;
    cyc(1'b0, 1'b0, 32'h0, 1'b0, acked);
    chk("t6_busy", {31'b0, fetch_busy_o}, 32'd1);
    #2 rst_i = 1'b0;
    #1;
    chk("t6_req", {31'b0, mem_req_o}, 32'd0);
    chk("t6_valid", {31'b0, inst_valid_o}, 32'd0);
    chk("t6_busy0", {31'b0, fetch_busy_o}, 32'd0);
    chk("t6_pc", pc_o, 32'h0);
    @(negedge clk);
    rst_i = 1'b1; wait_cnt = 0; killing = 1'b0;
    chk("sb_empty", 32'(exp_q.size()), 32'd0);

    // T6: PC wrap from RESET_PC = FFFF_FFFC
    start1_i = 1'b1;
    @(posedge clk);
    #1 start1_i = 1'b0;
    @(negedge clk);
    chk("wrap_req", {31'b0, req1_o}, 32'd1);
    chk("wrap_addr0", addr1_o, 32'hFFFF_FFFC);
    ack1_i = 1'b1; data1_i = 32'h1234_5678;
    @(posedge clk);
    #1 ack1_i = 1'b0;
    chk("wrap_pc", pc1_o, 32'hFFFF_FFFC);
    chk("wrap_inst", inst1_o, 32'h1234_5678);
    chk("wrap_valid", {31'b0, valid1_o}, 32'd1);
    chk("wrap_addr1", addr1_o, 32'h0);
    $display("wrap fetch pc=%h next_addr=%h", pc1_o, addr1_o);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
